// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding and stream framing constants.
package program_loader_pkg;

    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned LEN_W          = LEN_BYTES * 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loader_state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Packs little-endian bytes into 32-bit words; exposes the completed word in the
// same cycle its last byte is accepted so the caller can latch it directly.
module byte_word_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_en,
    output logic [31:0] word_c,
    output logic        word_full_c
);

    logic [LANE_W-1:0]                lane;
    logic [BYTES_PER_WORD-2:0][7:0]   lanes;

    // Lanes 0..2 are stored; the top lane is taken straight from byte_in.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane  <= '0;
            lanes <= '0;
        end else if (byte_en) begin
            lane <= lane + LANE_W'(1);
            for (int i = 0; i < int'(BYTES_PER_WORD) - 1; i++) begin
                if (lane == LANE_W'(i)) begin
                    lanes[i] <= byte_in;
                end
            end
        end
    end

    assign word_c      = {byte_in, lanes};
    assign word_full_c = byte_en && (lane == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed little-endian image into program memory and holds
// the core in reset until the whole image has been written.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned MEM_SIZE   = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    loader_state_e         state, state_d;
    logic [LEN_W-1:0]      length, length_d;
    logic [CNT_W-1:0]      words_written_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [31:0]           mem_wdata_d;
    logic                  byte_ready_d;
    logic                  mem_we_d;
    logic                  done_d;
    logic                  error_d;
    logic                  cpu_reset_hold_d;
    logic                  clear_c;
    logic                  transfer_c;
    logic                  data_en_c;
    logic [LEN_W-1:0]      hdr_len_c;
    logic [31:0]           word_c;
    logic                  word_full_c;

    assign transfer_c = byte_valid && byte_ready;
    assign data_en_c  = transfer_c && (state == DATA);
    assign hdr_len_c  = {byte_in, length[7:0]};

    byte_word_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear_c),
        .byte_in     (byte_in),
        .byte_en     (data_en_c),
        .word_c      (word_c),
        .word_full_c (word_full_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            length         <= '0;
            words_written  <= '0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            byte_ready     <= 1'b0;
            mem_we         <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            cpu_reset_hold <= 1'b1;
        end else begin
            state          <= state_d;
            length         <= length_d;
            words_written  <= words_written_d;
            mem_addr       <= mem_addr_d;
            mem_wdata      <= mem_wdata_d;
            byte_ready     <= byte_ready_d;
            mem_we         <= mem_we_d;
            done           <= done_d;
            error          <= error_d;
            cpu_reset_hold <= cpu_reset_hold_d;
        end
    end

    // Next state; outputs are decoded from the next state so they line up with it.
    always_comb begin
        state_d         = state;
        length_d        = length;
        words_written_d = words_written;
        mem_addr_d      = mem_addr;
        mem_wdata_d     = mem_wdata;
        clear_c         = 1'b0;

        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d         = LEN_LO;
                    clear_c         = 1'b1;
                    words_written_d = '0;
                    length_d        = '0;
                end
            end
            LEN_LO: begin
                if (transfer_c) begin
                    length_d[7:0] = byte_in;
                    state_d       = LEN_HI;
                end
            end
            LEN_HI: begin
                if (transfer_c) begin
                    length_d[15:8] = byte_in;
                    if (hdr_len_c == '0) begin
                        state_d = DONE;
                    end else if (hdr_len_c > LEN_W'(MEM_SIZE)) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (word_full_c) begin
                    state_d     = WRITE;
                    mem_addr_d  = words_written[ADDR_WIDTH-1:0];
                    mem_wdata_d = word_c;
                end
            end
            WRITE: begin
                words_written_d = words_written + CNT_W'(1);
                if (LEN_W'(words_written_d) == length) begin
                    state_d = DONE;
                end else begin
                    state_d = DATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        byte_ready_d     = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
        mem_we_d         = (state_d == WRITE);
        done_d           = (state_d == DONE);
        error_d          = (state_d == ERROR);
        cpu_reset_hold_d = (state_d != DONE);
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: expected writes are queued as bytes are
// sent and compared as mem_we strobes appear.
module tb_program_loader;

    localparam int unsigned ADDR_WIDTH = 7;
    localparam int unsigned MEM_SIZE   = 128;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  cpu_reset_hold;
    logic                  done;
    logic                  error;
    logic [ADDR_WIDTH:0]   words_written;

    program_loader #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_SIZE   (MEM_SIZE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .byte_in        (byte_in),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .cpu_reset_hold (cpu_reset_hold),
        .done           (done),
        .error          (error),
        .words_written  (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    int          write_cnt;
    int          wc0;
    logic [6:0]  last_addr;
    logic [38:0] exp_q[$];
    logic [38:0] exp_e;
    bit          gaps_on;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            write_cnt++;
            last_addr = mem_addr;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(exp_e[38:32]));
                check("wr_data", mem_wdata, exp_e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int budget;
        byte_valid = 1'b0;
        if (gaps_on) repeat ($urandom_range(0, 2)) tick();
        byte_in    = b;
        byte_valid = 1'b1;
        budget     = 0;
        while (!byte_ready && budget < 200) begin
            tick();
            budget++;
        end
        if (!byte_ready) begin
            check("byte_ready_timeout", 32'd0, 32'd1);
            byte_valid = 1'b0;
        end else begin
            tick();
            byte_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [6:0] addr, input logic [31:0] w);
        exp_q.push_back({addr, w});
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end();
        int budget;
        budget = 0;
        while (!(done || error) && budget < 200) begin
            tick();
            budget++;
        end
        if (!(done || error)) check("end_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        write_cnt  = 0;
        last_addr  = '0;
        gaps_on    = 1'b0;
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (2) tick();

        check("rst_hold",   32'(cpu_reset_hold), 32'd1);
        check("rst_ready",  32'(byte_ready),     32'd0);
        check("rst_we",     32'(mem_we),         32'd0);
        check("rst_done",   32'(done),           32'd0);
        check("rst_error",  32'(error),          32'd0);
        check("rst_words",  32'(words_written),  32'd0);
        reset = 1'b0;
        tick();

        // Two-word image.
        pulse_start();
        check("start_ready", 32'(byte_ready), 32'd1);
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(7'd0, 32'h0000_0013);
        send_word(7'd1, 32'h0010_00B3);
        wait_end();
        check("two_done",  32'(done),           32'd1);
        check("two_hold",  32'(cpu_reset_hold), 32'd0);
        check("two_error", 32'(error),          32'd0);
        check("two_words", 32'(words_written),  32'd2);
        check("two_ready", 32'(byte_ready),     32'd0);
        check("two_q",     32'(exp_q.size()),   32'd0);

        // Zero-length image; restart from DONE re-asserts the hold.
        wc0 = write_cnt;
        pulse_start();
        check("restart_hold", 32'(cpu_reset_hold), 32'd1);
        check("restart_done", 32'(done),           32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_end();
        check("zero_done",   32'(done),            32'd1);
        check("zero_words",  32'(words_written),   32'd0);
        check("zero_writes", 32'(write_cnt - wc0), 32'd0);

        // Oversized header.
        wc0 = write_cnt;
        pulse_start();
        send_byte(8'h81);
        send_byte(8'h00);
        wait_end();
        repeat (3) tick();
        check("big_error",  32'(error),            32'd1);
        check("big_done",   32'(done),             32'd0);
        check("big_hold",   32'(cpu_reset_hold),   32'd1);
        check("big_ready",  32'(byte_ready),       32'd0);
        check("big_writes", 32'(write_cnt - wc0),  32'd0);

        // Full-size image with random valid gaps.
        gaps_on = 1'b1;
        wc0     = write_cnt;
        pulse_start();
        send_byte(8'h80);
        send_byte(8'h00);
        for (int i = 0; i < 128; i++) begin
            send_word(7'(i), $urandom);
        end
        wait_end();
        check("full_writes", 32'(write_cnt - wc0), 32'd128);
        check("full_last",   32'(last_addr),       32'd127);
        check("full_words",  32'(words_written),   32'd128);
        check("full_done",   32'(done),            32'd1);
        check("full_hold",   32'(cpu_reset_hold),  32'd0);
        check("full_q",      32'(exp_q.size()),    32'd0);

        // Reset in the middle of a word, then a fresh one-word load.
        gaps_on = 1'b0;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b1;
        repeat (2) tick();
        check("mid_ready", 32'(byte_ready),     32'd0);
        check("mid_words", 32'(words_written),  32'd0);
        check("mid_hold",  32'(cpu_reset_hold), 32'd1);
        check("mid_done",  32'(done),           32'd0);
        reset = 1'b0;
        tick();
        wc0 = write_cnt;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(7'd0, 32'h8765_4321);
        wait_end();
        check("fresh_done",   32'(done),            32'd1);
        check("fresh_words",  32'(words_written),   32'd1);
        check("fresh_writes", 32'(write_cnt - wc0), 32'd1);
        check("fresh_q",      32'(exp_q.size()),    32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
